// File: rtl/sa_pkg.sv
// sa_pkg: controller state encoding and compute-window length for the systolic tile sequencer
package sa_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, DONE} ctrl_state_t;
    function automatic int comp_cyc(input int n, input int k);
        return k + 2 * n - 2;
    endfunction
endpackage

// File: rtl/sa_beat_counter.sv
// sa_beat_counter: clearable up-counter that holds at LAST instead of wrapping
module sa_beat_counter #(
    parameter int W    = 3,
    parameter int LAST = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         last
);
    assign last = count == W'(LAST);
    always_ff @(posedge clk)
        if (rst || clr) count <= '0;
        else if (inc && !last) count <= count + 1'b1;
endmodule

// File: rtl/sa_tile_controller.sv
// sa_tile_controller: load/compute/drain sequencer for an NxN systolic tile with inner dimension K
// Define SA_CTRL_PERF_EN to add saturating load/drain stall counters.
module sa_tile_controller
    import sa_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 8,
    localparam int PTR_W = $clog2((K > N) ? K : N),
    localparam int COMP_CYC = comp_cyc(N, K),
    localparam int CP_W = $clog2(COMP_CYC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    output logic             done,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic             b_valid,
    output logic             b_ready,
    output logic             enable,
    output logic             acc_clear,
    output logic             input_write,
    output logic             output_write,
    output logic             output_read,
    output logic [PTR_W-1:0] row_ptr,
    output logic             c_valid,
    input  logic             c_ready
`ifdef SA_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_load_stall,
    output logic [31:0]      perf_drain_stall
`endif
);
    ctrl_state_t state, state_nxt;
    logic [PTR_W-1:0] ld_cnt, dr_cnt;
    logic [CP_W-1:0] cp_cnt;
    logic ld_last, cp_last, dr_last, ld_hs;

    sa_beat_counter #(.W(PTR_W), .LAST(K - 1)) u_ld (
        .clk(clk), .rst(rst), .clr(state != LOAD), .inc(ld_hs),
        .count(ld_cnt), .last(ld_last)
    );
    sa_beat_counter #(.W(CP_W), .LAST(COMP_CYC - 1)) u_cp (
        .clk(clk), .rst(rst), .clr(state != COMPUTE), .inc(enable),
        .count(cp_cnt), .last(cp_last)
    );
    sa_beat_counter #(.W(PTR_W), .LAST(N - 1)) u_dr (
        .clk(clk), .rst(rst), .clr(state != DRAIN), .inc(output_read),
        .count(dr_cnt), .last(dr_last)
    );

    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = start ? LOAD : IDLE;
            LOAD:    state_nxt = (ld_hs && ld_last) ? COMPUTE : LOAD;
            COMPUTE: state_nxt = cp_last ? DRAIN : COMPUTE;
            DRAIN:   state_nxt = (c_ready && dr_last) ? DONE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ld_hs        = state == LOAD && a_valid && b_valid;
        ready        = state == IDLE;
        done         = state == DONE;
        a_ready      = state == LOAD;
        b_ready      = state == LOAD;
        input_write  = ld_hs;
        acc_clear    = ld_hs && ld_last;
        enable       = state == COMPUTE;
        output_write = state == COMPUTE && cp_cnt == CP_W'(COMP_CYC - 1);
        c_valid      = state == DRAIN;
        output_read  = state == DRAIN && c_ready;
        row_ptr      = state == LOAD ? ld_cnt : state == DRAIN ? dr_cnt : '0;
    end

`ifdef SA_CTRL_PERF_EN
    always_ff @(posedge clk)
        if (rst || (state == IDLE && start)) begin
            perf_load_stall  <= '0;
            perf_drain_stall <= '0;
        end else begin
            if (state == LOAD && !ld_hs && !(&perf_load_stall)) perf_load_stall <= perf_load_stall + 32'd1;
            if (c_valid && !c_ready && !(&perf_drain_stall)) perf_drain_stall <= perf_drain_stall + 32'd1;
        end
`endif
endmodule

// File: tb/tb_sa_tile_controller.sv
// tb_sa_tile_controller: directed self-checking bench for a 4x4, K=4 tile (compute window 10 cycles)
module tb_sa_tile_controller;
    localparam int N = 4;
    localparam int K = 4;
    localparam int COMP = K + 2 * N - 2;

    logic clk = 0, rst = 1, start = 0, a_valid = 0, b_valid = 0, c_ready = 0;
    logic ready, done, a_ready, b_ready, enable, acc_clear;
    logic input_write, output_write, output_read, c_valid;
    logic [1:0] row_ptr;
`ifdef SA_CTRL_PERF_EN
    logic [31:0] perf_load_stall, perf_drain_stall;
`endif
    int n_chk = 0, n_err = 0, cyc = 0, done_at = 0, d1 = 0;

    sa_tile_controller #(.N(N), .K(K)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready), .done(done),
        .a_valid(a_valid), .a_ready(a_ready), .b_valid(b_valid), .b_ready(b_ready),
        .enable(enable), .acc_clear(acc_clear), .input_write(input_write),
        .output_write(output_write), .output_read(output_read), .row_ptr(row_ptr),
        .c_valid(c_valid), .c_ready(c_ready)
`ifdef SA_CTRL_PERF_EN
        , .perf_load_stall(perf_load_stall), .perf_drain_stall(perf_drain_stall)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one tile from IDLE; a_off bit t drops a_valid in load cycle t,
    // c_ready is held low for st_len cycles on row st_row, poke pulses start mid-tile.
    task automatic run_tile(input logic [15:0] a_off, input int st_row, input int st_len, input bit poke);
        int w, t, r, s, ls;
        start = 1; a_valid = 0; b_valid = 1; c_ready = 0;
        tick();
        start = 0; w = 0; t = 0; ls = 0;
        while (w < K && t < 16) begin
            a_valid = !a_off[t];
            start = poke && t == 1;
            #1;
            check("ld_a_ready", a_ready, 1);
            check("ld_b_ready", b_ready, 1);
            check("ld_write", input_write, a_valid);
            check("ld_ptr", row_ptr, w);
            check("ld_acc_clear", acc_clear, a_valid && w == K - 1);
            if (a_valid) w++; else ls++;
            t++;
            tick();
        end
        check("ld_beats", w, K);
        a_valid = 0; start = 0;
        for (int i = 0; i < COMP; i++) begin
            #1;
            check("cp_enable", enable, 1);
            check("cp_out_write", output_write, i == COMP - 1);
            check("cp_a_ready", a_ready, 0);
            tick();
        end
        r = 0; s = 0; t = 0;
        while (r < N && t < 40) begin
            c_ready = !(r == st_row && s < st_len);
            start = poke && t == 0;
            #1;
            check("dr_c_valid", c_valid, 1);
            check("dr_ptr", row_ptr, r);
            check("dr_read", output_read, c_ready);
            check("dr_enable", enable, 0);
            if (c_ready) r++; else s++;
            t++;
            tick();
        end
        check("dr_rows", r, N);
        c_ready = 0; start = 0;
        #1;
        check("done_pulse", done, 1);
        check("done_ready", ready, 0);
        check("done_c_valid", c_valid, 0);
`ifdef SA_CTRL_PERF_EN
        check("perf_load", perf_load_stall, ls);
        check("perf_drain", perf_drain_stall, s);
`endif
        done_at = cyc;
        tick();
        check("idle_ready", ready, 1);
        check("idle_done", done, 0);
    endtask

    initial begin
        tick(); tick();
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_enable", enable, 0);
        check("rst_a_ready", a_ready, 0);
        check("rst_c_valid", c_valid, 0);
        check("rst_ptr", row_ptr, 0);
`ifdef SA_CTRL_PERF_EN
        check("rst_perf_load", perf_load_stall, 0);
        check("rst_perf_drain", perf_drain_stall, 0);
`endif
        rst = 0;
        tick();
        run_tile(16'h0000, -1, 0, 0);
        run_tile(16'h002A, -1, 0, 0);
        run_tile(16'h0000, 2, 3, 0);
        start = 1; a_valid = 1; b_valid = 1;
        tick();
        start = 0;
        repeat (K + 5) tick();
        check("rst_mid_enable", enable, 1);
        rst = 1;
        tick();
        rst = 0; a_valid = 0;
        #1;
        check("abort_ready", ready, 1);
        check("abort_enable", enable, 0);
        check("abort_done", done, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_done", done, 0);
        end
        run_tile(16'h0000, -1, 0, 0);
        run_tile(16'h0000, -1, 0, 1);
        d1 = done_at;
        run_tile(16'h0000, -1, 0, 1);
        check("b2b_spacing", done_at - d1, 20);
        run_tile(16'h0006, 1, 3, 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
